// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] RV_NOP   = 32'h0000_0013;

  // One queue slot: program counter plus the fetched instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch buffer between fetch and decode.
// Accepts up to two in-order {pc, instr} pairs per cycle and presents up
// to two to decode; a flush drops everything. Entries appear on the read
// side one cycle after they are written (no bypass).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,  // power of two, >= 4
  parameter int unsigned XLEN  = 32         // must match fq_entry_t field width
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid0,
  input  logic [XLEN-1:0]            in_pc0,
  input  logic [XLEN-1:0]            in_instr0,
  input  logic                       in_valid1,
  input  logic [XLEN-1:0]            in_pc1,
  input  logic [XLEN-1:0]            in_instr1,
  output logic                       in_ready,
  output logic                       out_valid0,
  output logic [XLEN-1:0]            out_pc0,
  output logic [XLEN-1:0]            out_instr0,
  output logic                       out_valid1,
  output logic [XLEN-1:0]            out_pc1,
  output logic [XLEN-1:0]            out_instr1,
  input  logic [1:0]                 deq,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_enq;
  logic [1:0]        w_n_in;
  logic [CW-1:0]     w_deq_ext;
  logic [CW-1:0]     w_n_out;
  logic [CW-1:0]     w_count_nxt;
  logic [PW-1:0]     w_wr_ptr1;
  logic [PW-1:0]     w_rd_ptr1;

  // in_ready looks only at registered occupancy so deq never reaches it.
  assign in_ready  = (r_count <= CW'(DEPTH - 2));
  assign w_enq     = in_ready & ~flush;
  // Slot 1 only counts when slot 0 is also valid.
  assign w_n_in    = w_enq ? {in_valid0 & in_valid1, in_valid0 & ~in_valid1} : 2'd0;
  assign w_deq_ext = {{(CW-2){1'b0}}, deq};
  // Saturate so an over-eager decode cannot underflow the queue.
  assign w_n_out   = (w_deq_ext > r_count) ? r_count : w_deq_ext;
  assign w_count_nxt = r_count + CW'(w_n_in) - w_n_out;
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);
  assign count     = r_count;

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_enq && in_valid0) begin
      r_mem[r_wr_ptr] <= '{pc: in_pc0, instr: in_instr0};
      if (in_valid1)
        r_mem[w_wr_ptr1] <= '{pc: in_pc1, instr: in_instr1};
    end
  end

  // Pointer and occupancy update; flush overrides any enqueue/dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_n_out[PW-1:0];
      r_wr_ptr <= r_wr_ptr + PW'(w_n_in);
      r_count  <= w_count_nxt;
    end
  end

  // Read side: head and next entry, NOP/zero when a slot is empty.
  always_comb begin
    out_valid0 = (r_count >= CW'(1));
    out_valid1 = (r_count >= CW'(2));
    out_pc0    = '0;
    out_instr0 = RV_NOP;
    out_pc1    = '0;
    out_instr1 = RV_NOP;
    if (out_valid0) begin
      out_pc0    = r_mem[r_rd_ptr].pc;
      out_instr0 = r_mem[r_rd_ptr].instr;
    end
    if (out_valid1) begin
      out_pc1    = r_mem[w_rd_ptr1].pc;
      out_instr1 = r_mem[w_rd_ptr1].instr;
    end
  end

  // Decode asking for more entries than are held is a protocol error.
  a_deq_le_count: assert property (@(posedge clk) disable iff (!rst_n)
                                   (flush || (w_deq_ext <= r_count)))
    else $warning("fetch_queue: deq exceeds occupancy");

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction fetch buffer inside rv32i_cpu.
- Sits between the two-port fetch stage (instr_rdata / instr_rdata1 path) and decode.
- Accepts up to two {pc, instr} pairs per cycle and presents up to two in-order pairs to decode.
- Decouples fetch from decode stalls; drops all contents on a branch-redirect flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 4.
- XLEN, 32, width of pc and instr fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  branch taken / redirect; discards queue contents.
- in_valid0  in  1  fetch slot 0 valid.
- in_pc0  in  XLEN  pc of slot 0.
- in_instr0  in  XLEN  instruction of slot 0.
- in_valid1  in  1  fetch slot 1 valid (pc0+4); honoured only with in_valid0.
- in_pc1  in  XLEN  pc of slot 1.
- in_instr1  in  XLEN  instruction of slot 1.
- in_ready  out  1  at least 2 free entries this cycle.
- out_valid0  out  1  head entry valid.
- out_pc0  out  XLEN  head pc.
- out_instr0  out  XLEN  head instruction.
- out_valid1  out  1  second entry valid.
- out_pc1  out  XLEN  second pc.
- out_instr1  out  XLEN  second instruction.
- deq  in  2  entries consumed by decode this cycle: 0, 1 or 2.
- count  out  $clog2(DEPTH)+1  occupancy, for debug trace.

Behaviour:
- Storage and pointers:
  - Circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and a count register.
- Reset (rst_n low, asynchronous):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs: out_valid0/1 = 0, in_ready = 1, count = 0.
  - out_pc0/1 = 0; out_instr0/1 = NOP (0x00000013).
  - Storage contents are not reset.
- Enqueue:
  - Takes effect only when in_ready = 1 and flush = 0.
  - in_ready = (count <= DEPTH-2), computed from the registered count only. Same-cycle deq does not raise it, so there is no combinational path from deq to in_ready.
  - Write count n_in = in_valid0 + (in_valid0 & in_valid1).
  - Slot 0 is written at wr_ptr, slot 1 at wr_ptr+1; wr_ptr advances by n_in.
  - in_valid1 without in_valid0 is ignored.
- Dequeue:
  - n_out = min(deq, count), saturating; deq > count is a protocol violation, flagged by a simulation assertion.
  - rd_ptr advances by n_out.
- Occupancy update:
  - count_next = count + n_in - n_out. Simultaneous enqueue and dequeue is legal in the same cycle.
- Read side:
  - Combinational from storage: out_valid0 = (count >= 1), out_valid1 = (count >= 2).
  - An invalid output slot drives pc = 0 and instr = NOP.
- Latency:
  - An enqueued entry is visible on the outputs the cycle after the write. There is no bypass.
  - Empty queue plus enqueue: out_valid0 = 0 this cycle, 1 next cycle.
- Flush (highest priority):
  - Next state is rd_ptr = wr_ptr = count = 0.
  - Same-cycle enqueue and deq are ignored.
  - Outputs are still driven from the current state during the flush cycle; decode must itself squash on flush.
- Wrap-around:
  - A two-entry write or read straddling index DEPTH-1 → 0 must keep program order.
- Full:
  - count = DEPTH-1 or DEPTH gives in_ready = 0.
  - count never exceeds DEPTH, so there is no overflow path.
- Reset mid-operation:
  - Asynchronous clear as above; the first enqueue after rst_n deasserts is accepted normally.

Decomposition:
- rv32i_pkg gains:
  - FQ_DEPTH default constant.
  - RV_NOP = 32'h00000013.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fq_entry_t.
- No sub-module; storage is an inline fq_entry_t array.
- Pointer/count logic stays in one always_ff with an async-low reset branch.

Test Plan:
- Reset, then enqueue pairs (0x0, 0x00500093) and (0x4, 0x00A00113) with deq = 0 → next cycle out_valid0 = out_valid1 = 1, out_pc0 = 0x0, out_pc1 = 0x4, count = 2.
- Fill to 4 entries with deq = 0 → in_ready = 0 at count 3 and 4; a further in_valid0 is ignored and count stays 4.
- Steady state, enqueue 2 and deq = 2 every cycle for 10 cycles starting pc 0x0 → count constant; head pc sequence 0x0, 0x8, 0x10, ... with correct wrap across index 3 → 0.
- count = 3, flush = 1 with in_valid0 = 1 and deq = 2 → next cycle count = 0, out_valid0 = 0, out_instr0 = 0x00000013.
- count = 1, deq = 2 → assertion fires, count becomes 0 with no underflow.
- rst_n pulsed low mid-cycle at count = 2 → outputs clear immediately without a clock edge; enqueue of pc 0x100 after release → out_pc0 = 0x100 one cycle later.
